pipe_ctrl: RTL

- Central sequencer for the five-stage pipeline with interrupt support.
- Drives the write-enable and clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves load-use stalls, data-memory busy freezes, branch/jump flushes, interrupt entry and ERET return.
- Owns EPC and the in-handler flag.

---
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencer.
// Drives stage write-enables and clears. Resolves load-use stalls,
// data-memory freezes, branch flushes, interrupt entry and ERET return.
// Owns EPC and the in-handler flag.
// Optional build macro PIPE_STALL_CNT_EN adds a saturating stall-cycle counter.
// Without it, stall_cnt is tied to zero.
module pipe_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_rd,
  input  logic [4:0]       ex_wa,
  input  logic             ex_br_taken,
  input  logic             dm_busy,
  input  logic             int_req,
  input  logic             int_en,
  input  logic             eret_mem,
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic             mem_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      mem_pc,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             idex_wr,
  output logic             exmem_wr,
  output logic             memwb_wr,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic [1:0]       pc_sel,
  output logic [31:0]      epc,
  output logic             int_ack,
  output logic             in_handler,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] INT_FLUSH  = 2'd1;
  localparam logic [1:0] ERET_FLUSH = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        load_use;
  logic        take_int;
  logic        capture;
  logic        stall_cyc;
  logic [31:0] oldest_pc;

  // Hazard detection, interrupt qualification and oldest in-flight PC
  always_comb begin
    load_use = ex_mem_rd && (ex_wa != '0) &&
               ((id_use_rs && (id_rs == ex_wa)) || (id_use_rt && (id_rt == ex_wa)));
    take_int = int_req && int_en && !in_handler;
    if (mem_valid)     oldest_pc = mem_pc;
    else if (ex_valid) oldest_pc = ex_pc;
    else if (id_valid) oldest_pc = id_pc;
    else               oldest_pc = if_pc;
  end

  // Stage control decode and next-state selection
  always_comb begin
    pc_wr     = 1'b1;
    ifid_wr   = 1'b1;
    idex_wr   = 1'b1;
    exmem_wr  = 1'b1;
    memwb_wr  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    pc_sel    = 2'd0;
    int_ack   = 1'b0;
    capture   = 1'b0;
    stall_cyc = 1'b0;
    state_nxt = state;
    case (state)
      RUN: begin
        if (dm_busy) begin
          {pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr} = '0;
          stall_cyc = 1'b1;
        end else if (take_int) begin
          {pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr} = '0;
          capture   = 1'b1;
          state_nxt = INT_FLUSH;
        end else if (eret_mem) begin
          {pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr} = '0;
          state_nxt = ERET_FLUSH;
        end else if (ex_br_taken) begin
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
        end else if (load_use) begin
          pc_wr     = 1'b0;
          ifid_wr   = 1'b0;
          idex_clr  = 1'b1;
          stall_cyc = 1'b1;
        end
      end
      INT_FLUSH: begin
        ifid_clr  = 1'b1;
        idex_clr  = 1'b1;
        exmem_clr = 1'b1;
        memwb_clr = 1'b1;
        pc_sel    = 2'd1;
        int_ack   = 1'b1;
        state_nxt = RUN;
      end
      ERET_FLUSH: begin
        ifid_clr  = 1'b1;
        idex_clr  = 1'b1;
        exmem_clr = 1'b1;
        pc_sel    = 2'd2;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State, EPC capture and handler flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      epc        <= '0;
      in_handler <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) epc <= oldest_pc;
      if (state == INT_FLUSH)       in_handler <= 1'b1;
      else if (state == ERET_FLUSH) in_handler <= 1'b0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of frozen-PC cycles caused by memory busy or load-use
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (stall_cyc && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign stall_cnt = cnt;
`else
  logic unused_stall;
  assign unused_stall = stall_cyc;
  assign stall_cnt    = '0;
`endif

  // Handler entry address must be word aligned whenever it is selected
  a_handler_aligned: assert property (@(posedge clk) disable iff (!rst)
    (pc_sel != 2'd1) || (HANDLER_ADDR[1:0] == 2'b00));

endmodule
